// File: rtl/spi_slave.sv
// spi_slave: SPI target oversampled in the i_clk domain with a 16-bit Wishbone register file.
module spi_slave (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        spi_sck,
  input  logic        spi_mosi,
  output logic        spi_miso,
  input  logic        spi_ss,
  input  logic [23:0] wb_adr,
  input  logic        wb_cyc,
  input  logic        wb_stb,
  output logic        wb_ack,
  input  logic        wb_we,
  input  logic [15:0] wb_i_dat,
  output logic [15:0] wb_o_dat,
  output logic        o_irq
);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state_q, state_d;
  logic sck_s1_q, sck_s2_q, sck_d_q, mosi_s1_q, mosi_s2_q, ss_s1_q, ss_s2_q, ss_d_q;
  logic [1:0] mode_q, mode_d, act_q, act_d;
  logic [7:0] hold_q, hold_d, tx_q, tx_d, rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
  logic [2:0] cnt_q, cnt_d;
  logic tx_full_q, tx_full_d, rx_valid_q, rx_valid_d, ovr_q, ovr_d, miso_q, miso_d;
  logic acc, wr, pop, ss_fall, ss_rise, sck_rise, sck_fall, lead, trail, smp, shf, done;
  logic [7:0] load_val, rx_next;
  logic unused;
  assign unused = ^wb_i_dat[15:8];
  assign acc = wb_cyc & wb_stb;
  assign wb_ack = acc;
  assign wr = acc & wb_we;
  assign pop = acc & ~wb_we & (wb_adr == 24'd1);
  assign ss_fall = ss_d_q & ~ss_s2_q;
  assign ss_rise = ~ss_d_q & ss_s2_q;
  assign sck_rise = sck_s2_q & ~sck_d_q;
  assign sck_fall = ~sck_s2_q & sck_d_q;
  assign lead = act_q[1] ? sck_fall : sck_rise;
  assign trail = act_q[1] ? sck_rise : sck_fall;
  // edges only count inside a frame; a closing ss edge overrides any sck edge in the same cycle
  assign smp = (state_q == ACTIVE) & ~ss_rise & (act_q[0] ? trail : lead);
  assign shf = (state_q == ACTIVE) & ~ss_rise & (act_q[0] ? lead : trail);
  assign done = smp & (cnt_q == 3'd7);
  assign load_val = tx_full_q ? hold_q : 8'hFF;
  assign rx_next = {rx_sh_q[6:0], mosi_s2_q};
  assign spi_miso = miso_q;
  assign o_irq = rx_valid_q;
  assign wb_o_dat = (wb_adr == 24'd1) ? {8'b0, rx_data_q} :
                    (wb_adr == 24'd2) ? {12'b0, state_q == ACTIVE, ovr_q, ~tx_full_q, rx_valid_q} :
                    (wb_adr == 24'd3) ? {14'b0, mode_q} : 16'b0;
  always_comb begin
    state_d = state_q;
    mode_d = mode_q;
    act_d = act_q;
    hold_d = hold_q;
    tx_d = tx_q;
    rx_sh_d = rx_sh_q;
    rx_data_d = rx_data_q;
    cnt_d = cnt_q;
    tx_full_d = tx_full_q;
    ovr_d = ovr_q;
    miso_d = miso_q;
    rx_valid_d = done | (rx_valid_q & ~pop);
    if (ss_fall) begin
      state_d = ACTIVE;
      act_d = mode_q;
      tx_d = load_val;
      tx_full_d = 1'b0;
      cnt_d = 3'd0;
      miso_d = mode_q[0] ? 1'b1 : load_val[7];
    end
    if (ss_rise) begin
      state_d = IDLE;
      cnt_d = 3'd0;
      miso_d = 1'b1;
    end
    if (shf) miso_d = tx_q[3'd7 - cnt_q];
    if (smp) begin
      rx_sh_d = rx_next;
      cnt_d = cnt_q + 3'd1;
    end
    if (done) begin
      rx_data_d = rx_next;
      tx_d = load_val;
      tx_full_d = 1'b0;
    end
    if (wr & (wb_adr == 24'd2) & wb_i_dat[2]) ovr_d = 1'b0;
    if (done & rx_valid_q & ~pop) ovr_d = 1'b1;
    // a bus write lands after any shifter load, so the load sees the old holding value
    if (wr & (wb_adr == 24'd0)) begin
      hold_d = wb_i_dat[7:0];
      tx_full_d = 1'b1;
    end
    if (wr & (wb_adr == 24'd3)) mode_d = wb_i_dat[1:0];
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sck_s1_q <= 1'b0;
      sck_s2_q <= 1'b0;
      sck_d_q <= 1'b0;
      mosi_s1_q <= 1'b0;
      mosi_s2_q <= 1'b0;
      ss_s1_q <= 1'b0;
      ss_s2_q <= 1'b0;
      ss_d_q <= 1'b0;
      state_q <= IDLE;
      mode_q <= 2'b00;
      act_q <= 2'b00;
      hold_q <= 8'h00;
      tx_q <= 8'h00;
      rx_sh_q <= 8'h00;
      rx_data_q <= 8'h00;
      cnt_q <= 3'd0;
      tx_full_q <= 1'b0;
      rx_valid_q <= 1'b0;
      ovr_q <= 1'b0;
      miso_q <= 1'b1;
    end else begin
      sck_s1_q <= spi_sck;
      sck_s2_q <= sck_s1_q;
      sck_d_q <= sck_s2_q;
      mosi_s1_q <= spi_mosi;
      mosi_s2_q <= mosi_s1_q;
      ss_s1_q <= spi_ss;
      ss_s2_q <= ss_s1_q;
      ss_d_q <= ss_s2_q;
      state_q <= state_d;
      mode_q <= mode_d;
      act_q <= act_d;
      hold_q <= hold_d;
      tx_q <= tx_d;
      rx_sh_q <= rx_sh_d;
      rx_data_q <= rx_data_d;
      cnt_q <= cnt_d;
      tx_full_q <= tx_full_d;
      rx_valid_q <= rx_valid_d;
      ovr_q <= ovr_d;
      miso_q <= miso_d;
    end
  end
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed SPI master plus Wishbone accesses against hand-computed results.
module tb_spi_slave;
  logic clk = 1'b0, rst = 1'b1;
  logic spi_sck = 1'b0, spi_mosi = 1'b0, spi_ss = 1'b1, spi_miso;
  logic [23:0] wb_adr = 24'd0;
  logic wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0, wb_ack, o_irq;
  logic [15:0] wb_i_dat = 16'd0, wb_o_dat, rd, pop_val;
  logic [7:0] mi, mi2;
  bit cpol, cpha;
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  spi_slave dut (
    .i_clk(clk), .i_rst(rst), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .spi_ss(spi_ss), .wb_adr(wb_adr), .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_ack(wb_ack),
    .wb_we(wb_we), .wb_i_dat(wb_i_dat), .wb_o_dat(wb_o_dat), .o_irq(o_irq)
  );
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic wb_write(input logic [23:0] a, input logic [15:0] d);
    @(negedge clk);
    wb_cyc = 1'b1;
    wb_stb = 1'b1;
    wb_we = 1'b1;
    wb_adr = a;
    wb_i_dat = d;
    @(negedge clk);
    wb_cyc = 1'b0;
    wb_stb = 1'b0;
    wb_we = 1'b0;
  endtask
  task automatic wb_read(input logic [23:0] a, output logic [15:0] d);
    @(negedge clk);
    wb_cyc = 1'b1;
    wb_stb = 1'b1;
    wb_we = 1'b0;
    wb_adr = a;
    #1 d = wb_o_dat;
    @(negedge clk);
    wb_cyc = 1'b0;
    wb_stb = 1'b0;
  endtask
  // pe: pop rx_data on the exact i_clk cycle the last sample completes the byte (CPHA=0 only)
  task automatic xfer(input logic [7:0] mo, input int nb, input bit pe, output logic [7:0] m);
    m = 8'h00;
    for (int i = 7; i > 7 - nb; i--) begin
      if (!cpha) spi_mosi = mo[i];
      #80 spi_sck = ~cpol;
      if (!cpha) m = {m[6:0], spi_miso};
      else spi_mosi = mo[i];
      if (pe && i == 0) begin
        #20;
        wb_cyc = 1'b1;
        wb_stb = 1'b1;
        wb_we = 1'b0;
        wb_adr = 24'd1;
        #4 pop_val = wb_o_dat;
        #2;
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
        #54;
      end else #80;
      spi_sck = cpol;
      if (cpha) m = {m[6:0], spi_miso};
    end
  endtask
  task automatic frame(input logic [7:0] mo, input bit pe, output logic [7:0] m);
    spi_sck = cpol;
    #80 spi_ss = 1'b0;
    xfer(mo, 8, pe, m);
    #80 spi_ss = 1'b1;
    #80;
  endtask
  initial begin
    #30 rst = 1'b0;
    #20;
    chk("rst_miso", 16'(spi_miso), 16'h1);
    chk("rst_irq", 16'(o_irq), 16'h0);
    chk("rst_ack", 16'(wb_ack), 16'h0);
    wb_read(24'd2, rd); chk("rst_status", rd, 16'h0002);
    wb_read(24'd3, rd); chk("rst_mode", rd, 16'h0000);
    wb_read(24'd1, rd); chk("rst_rxdata", rd, 16'h0000);
    wb_read(24'd5, rd); chk("unmapped", rd, 16'h0000);
    wb_write(24'd0, 16'h00A5);
    wb_read(24'd0, rd); chk("adr0_read", rd, 16'h0000);
    cpol = 0; cpha = 0;
    frame(8'h3C, 1'b0, mi);
    chk("m0_miso_byte", 16'(mi), 16'h00A5);
    wb_read(24'd2, rd); chk("m0_status", rd, 16'h0003);
    chk("m0_irq", 16'(o_irq), 16'h1);
    chk("m0_idle_miso", 16'(spi_miso), 16'h1);
    wb_read(24'd1, rd); chk("m0_rxdata", rd, 16'h003C);
    wb_read(24'd2, rd); chk("m0_popped", rd, 16'h0002);
    wb_write(24'd3, 16'h0003);
    wb_read(24'd3, rd); chk("m3_mode", rd, 16'h0003);
    wb_write(24'd0, 16'h0055);
    cpol = 1; cpha = 1;
    spi_sck = 1'b1;
    #80 spi_ss = 1'b0;
    xfer(8'h81, 8, 1'b0, mi);
    xfer(8'h7E, 8, 1'b0, mi2);
    #80 spi_ss = 1'b1;
    #80;
    chk("m3_byte0", 16'(mi), 16'h0055);
    chk("m3_byte1", 16'(mi2), 16'h00FF);
    wb_read(24'd2, rd); chk("m3_overrun", rd, 16'h0007);
    wb_write(24'd2, 16'h0004);
    wb_read(24'd2, rd); chk("m3_ovr_clear", rd, 16'h0003);
    wb_read(24'd1, rd); chk("m3_rxdata", rd, 16'h007E);
    wb_write(24'd3, 16'h0001);
    wb_write(24'd0, 16'h0096);
    cpol = 0; cpha = 1;
    frame(8'hC3, 1'b0, mi);
    chk("m1_miso_byte", 16'(mi), 16'h0096);
    wb_read(24'd1, rd); chk("m1_rxdata", rd, 16'h00C3);
    wb_write(24'd3, 16'h0002);
    wb_write(24'd0, 16'h0096);
    cpol = 1; cpha = 0;
    frame(8'hC3, 1'b0, mi);
    chk("m2_miso_byte", 16'(mi), 16'h0096);
    wb_read(24'd1, rd); chk("m2_rxdata", rd, 16'h00C3);
    wb_write(24'd3, 16'h0000);
    cpol = 0; cpha = 0;
    spi_sck = 1'b0;
    #80 spi_ss = 1'b0;
    xfer(8'hAB, 5, 1'b0, mi);
    #80 spi_ss = 1'b1;
    #80;
    wb_read(24'd2, rd); chk("partial_no_rx", rd, 16'h0002);
    frame(8'h12, 1'b0, mi);
    chk("partial_miso_ff", 16'(mi), 16'h00FF);
    wb_read(24'd1, rd); chk("partial_rxdata", rd, 16'h0012);
    wb_write(24'd0, 16'h0000);
    #80 spi_ss = 1'b0;
    xfer(8'h5A, 4, 1'b0, mi);
    chk("pre_rst_miso", 16'(spi_miso), 16'h0);
    rst = 1'b1;
    #30;
    chk("in_rst_miso", 16'(spi_miso), 16'h1);
    rst = 1'b0;
    xfer(8'hA5, 4, 1'b0, mi);
    chk("post_rst_miso", 16'(spi_miso), 16'h1);
    #80 spi_ss = 1'b1;
    #80;
    wb_read(24'd2, rd); chk("aborted_no_rx", rd, 16'h0002);
    frame(8'hF0, 1'b0, mi);
    chk("post_rst_miso_ff", 16'(mi), 16'h00FF);
    wb_read(24'd1, rd); chk("post_rst_rxdata", rd, 16'h00F0);
    frame(8'h11, 1'b0, mi);
    pop_val = 16'hDEAD;
    frame(8'h22, 1'b1, mi);
    chk("pop_old_byte", pop_val, 16'h0011);
    wb_read(24'd2, rd); chk("pop_status", rd, 16'h0003);
    wb_read(24'd1, rd); chk("pop_rxdata", rd, 16'h0022);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
